mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter for a single-ported synchronous SRAM with fixed wait states.
// Optional round-robin tie breaking is enabled with the macro MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          mem_r_en,
    input  logic          mem_w_en,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_rdata,
    output logic          mem_ready,
    output logic          freeze,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    output logic          sram_we,
    output logic          sram_oe
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          write_q, write_d;
    logic          prio_q, prio_d;
    logic [3:0]    wait_q, wait_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]   sram_wdata_q, sram_wdata_d;
    logic          sram_we_q, sram_we_d;
    logic          sram_oe_q, sram_oe_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          mem_ready_q, mem_ready_d;

    logic mem_req;
    logic pick_mem;

    // prio_q never leaves PORT_MEM unless fairness updates it, so the data port wins ties by default.
    assign mem_req  = mem_r_en | mem_w_en;
    assign pick_mem = mem_req && (!if_req || prio_q == PORT_MEM);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        write_d      = write_q;
        prio_d       = prio_q;
        wait_d       = wait_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = sram_we_q;
        sram_oe_d    = sram_oe_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req || if_req) begin
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_CYCLES);
                    if (pick_mem) begin
                        owner_d      = PORT_MEM;
                        write_d      = mem_w_en;
                        sram_addr_d  = mem_addr[AW+1:2];
                        sram_wdata_d = mem_wdata;
                        sram_we_d    = mem_w_en;
                        sram_oe_d    = !mem_w_en;
                    end else begin
                        owner_d     = PORT_IF;
                        write_d     = 1'b0;
                        sram_addr_d = if_addr[AW+1:2];
                        sram_we_d   = 1'b0;
                        sram_oe_d   = 1'b1;
                    end
`ifdef MEM_ARB_FAIRNESS_EN
                    prio_d = pick_mem ? PORT_IF : PORT_MEM;
`endif
                end
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d   = DONE;
                    sram_we_d = 1'b0;
                    sram_oe_d = 1'b0;
                    if (owner_q == PORT_MEM) begin
                        mem_ready_d = 1'b1;
                        if (!write_q) begin
                            mem_rdata_d = sram_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = sram_rdata;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= PORT_IF;
            write_q      <= 1'b0;
            prio_q       <= PORT_MEM;
            wait_q       <= 4'd0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            prio_q       <= prio_d;
            wait_q       <= wait_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_q    <= sram_we_d;
            sram_oe_q    <= sram_oe_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = sram_we_q;
    assign sram_oe    = sram_oe_q;
    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;

    assign freeze = (if_req && !if_ready_q) || (mem_req && !mem_ready_q);

    // Byte-lane bits and address bits above the SRAM range are intentionally dropped.
    logic unused_addr_bits;
    if (AW < 30) begin : g_hi_bits
        assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0], if_addr[31:AW+2], mem_addr[31:AW+2]};
    end else begin : g_no_hi_bits
        assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a WAIT_CYCLES=2 instance with an SRAM model,
// plus a WAIT_CYCLES=0 instance for back-to-back fetch timing.
module tb_mem_port_arbiter;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req, mem_r_en, mem_w_en;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [31:0]   if_rdata, mem_rdata, sram_wdata, sram_rdata;
    logic          if_ready, mem_ready, freeze, sram_we, sram_oe;
    logic [AW-1:0] sram_addr;

    logic          if_req0;
    logic [31:0]   if_addr0, if_rdata0, mem_rdata0, sram_wdata0, sram_rdata0;
    logic          if_ready0, mem_ready0, freeze0, sram_we0, sram_oe0;
    logic [AW-1:0] sram_addr0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(W), .AW(AW)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we(sram_we), .sram_oe(sram_oe)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0), .AW(AW)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
        .mem_r_en(1'b0), .mem_w_en(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
        .mem_rdata(mem_rdata0), .mem_ready(mem_ready0), .freeze(freeze0),
        .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0),
        .sram_we(sram_we0), .sram_oe(sram_oe0)
    );

    function automatic logic [31:0] pat(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(i) * 32'h0101_0003);
    endfunction

    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    assign sram_rdata  = sram_mem[sram_addr[7:0]];
    assign sram_rdata0 = 32'hA5A5_0000 | 32'(sram_addr0);

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            if (sram_we) sram_mem[sram_addr[7:0]] = sram_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          is_mem;
        logic          is_write;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
    } item_t;

    item_t       sb_q[$];
    item_t       it_mon;
    int          strobe_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic [AW-1:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_we;

    logic [31:0] exp_mem_rdata = 32'h0;
    logic [31:0] exp_if_rdata  = 32'h0;
    logic        prio_mem      = 1'b1;

    // Monitor: pops one expected transaction per ready pulse.
    always @(negedge clk) begin
        if (!rst) begin
            strobe_cnt  = 0;
            prev_strobe = 1'b0;
        end else if (if_ready || mem_ready) begin
            check_eq("single_ready", {63'd0, if_ready && mem_ready}, 64'd0);
            check_eq("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
            if (sb_q.size() != 0) begin
                it_mon = sb_q.pop_front();
                check_eq("owner", {63'd0, mem_ready}, {63'd0, it_mon.is_mem});
                check_eq("sram_addr", 64'(cap_addr), 64'(it_mon.addr));
                check_eq("direction", {63'd0, cap_we}, {63'd0, it_mon.is_write});
                check_eq("strobe_cycles", 64'(strobe_cnt), 64'(W + 1));
                check_eq("ready_after_strobe", {63'd0, prev_strobe}, 64'd1);
                if (it_mon.is_write) check_eq("sram_wdata", 64'(cap_wdata), 64'(it_mon.wdata));
                if (it_mon.is_mem) check_eq("mem_rdata", 64'(mem_rdata), 64'(it_mon.rdata));
                else               check_eq("if_rdata", 64'(if_rdata), 64'(it_mon.rdata));
                $display("[TB] txn port=%s wr=%0d sram_addr=0x%0h rdata=0x%08h strobes=%0d",
                         it_mon.is_mem ? "data" : "fetch", it_mon.is_write, cap_addr,
                         it_mon.is_mem ? mem_rdata : if_rdata, strobe_cnt);
            end
            strobe_cnt  = 0;
            prev_strobe = 1'b0;
        end else begin
            if (sram_oe || sram_we) begin
                if (strobe_cnt == 0) begin
                    cap_addr  = sram_addr;
                    cap_wdata = sram_wdata;
                    cap_we    = sram_we;
                end
                strobe_cnt++;
            end
            prev_strobe = sram_oe || sram_we;
        end
    end

    function automatic item_t make_item(input logic is_mem, input logic is_write,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        item_t it;
        it.is_mem   = is_mem;
        it.is_write = is_write;
        it.addr     = addr[AW+1:2];
        it.wdata    = wdata;
        if (is_write) begin
            ref_mem[addr[9:2]] = wdata;
            it.rdata = exp_mem_rdata;
        end else if (is_mem) begin
            exp_mem_rdata = ref_mem[addr[9:2]];
            it.rdata = exp_mem_rdata;
        end else begin
            exp_if_rdata = ref_mem[addr[9:2]];
            it.rdata = exp_if_rdata;
        end
`ifdef MEM_ARB_FAIRNESS_EN
        prio_mem = !is_mem;
`endif
        return it;
    endfunction

    task automatic wait_ready(input logic is_mem);
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (is_mem ? mem_ready : if_ready) break;
            cnt++;
            if (cnt > 40) begin
                check_eq("ready_timeout", {63'd0, is_mem ? mem_ready : if_ready}, 64'd1);
                break;
            end
        end
    endtask

    // mode: 0 fetch, 1 data read, 2 data write, 3 read+write asserted (write)
    // disturb: 1 change address after grant, 2 drop request after grant
    task automatic do_txn(input int mode, input logic [31:0] addr, input logic [31:0] wdata,
                          input int disturb);
        logic is_mem   = (mode != 0);
        logic is_write = (mode >= 2);
        logic rdy;
        logic exp_frz;
        logic disturbed = 1'b0;
        int   cnt = 0;
        sb_q.push_back(make_item(is_mem, is_write, addr, wdata));
        @(posedge clk); #1;
        if (is_mem) begin
            mem_r_en  = (mode == 1) || (mode == 3);
            mem_w_en  = is_write;
            mem_addr  = addr;
            mem_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        forever begin
            @(negedge clk);
            rdy = is_mem ? mem_ready : if_ready;
            exp_frz = (if_req && !if_ready) || ((mem_r_en || mem_w_en) && !mem_ready);
            check_eq("freeze", {63'd0, freeze}, {63'd0, exp_frz});
            if (rdy) break;
            if (disturb != 0 && !disturbed && (sram_oe || sram_we)) begin
                disturbed = 1'b1;
                mem_addr  = 32'hFFFF_FFFC;
                if_addr   = 32'hFFFF_FFFC;
                mem_wdata = 32'h0BAD_0BAD;
                if (disturb == 2) begin
                    if_req   = 1'b0;
                    mem_r_en = 1'b0;
                    mem_w_en = 1'b0;
                end
            end
            cnt++;
            if (cnt > 40) begin
                check_eq("ready_timeout", {63'd0, rdy}, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        if_req   = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        logic first_mem;
        int   gap, oe_cnt;
        if_req = 0; mem_r_en = 0; mem_w_en = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        if_req0 = 0; if_addr0 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        // Reset state, with a request held during reset that must not be granted.
        repeat (2) @(negedge clk);
        mem_r_en = 1'b1; mem_addr = 32'h10;
        repeat (2) @(negedge clk);
        check_eq("rst_sram_oe", {63'd0, sram_oe}, 64'd0);
        check_eq("rst_sram_we", {63'd0, sram_we}, 64'd0);
        check_eq("rst_sram_addr", 64'(sram_addr), 64'd0);
        check_eq("rst_sram_wdata", 64'(sram_wdata), 64'd0);
        check_eq("rst_if_rdata", 64'(if_rdata), 64'd0);
        check_eq("rst_mem_rdata", 64'(mem_rdata), 64'd0);
        check_eq("rst_readies", {62'd0, if_ready, mem_ready}, 64'd0);
        mem_r_en = 1'b0;
        rst = 1'b1;

        do_txn(1, 32'h0000_0010, 32'h0, 0);          // read DEADBEEF, sram_addr 4
        do_txn(2, 32'h0000_0100, 32'h1234_5678, 0);  // write, sram_addr 0x40
        do_txn(1, 32'h0000_0100, 32'h0, 0);
        do_txn(0, 32'h0000_0010, 32'h0, 0);
        do_txn(0, 32'h0000_0107, 32'h0, 0);          // low bits ignored
        do_txn(3, 32'h0000_0020, 32'hCAFE_F00D, 0);  // both enables -> write
        do_txn(1, 32'h0000_0020, 32'h0, 1);          // address changes in flight
        do_txn(2, 32'h0000_0030, 32'h5555_AAAA, 2);  // request dropped in flight
        do_txn(0, 32'h0000_0030, 32'h0, 2);
        do_txn(1, 32'h00FF_0008, 32'h0, 0);          // upper bits truncated to AW

        // Simultaneous requests.
        first_mem = prio_mem;
        @(posedge clk); #1;
        if (first_mem) begin
            sb_q.push_back(make_item(1'b1, 1'b0, 32'h44, 32'h0));
            sb_q.push_back(make_item(1'b0, 1'b0, 32'h40, 32'h0));
        end else begin
            sb_q.push_back(make_item(1'b0, 1'b0, 32'h40, 32'h0));
            sb_q.push_back(make_item(1'b1, 1'b0, 32'h44, 32'h0));
        end
        if_req = 1'b1; if_addr = 32'h40;
        mem_r_en = 1'b1; mem_addr = 32'h44;
        wait_ready(first_mem);
        @(posedge clk); #1;
        if (first_mem) mem_r_en = 1'b0; else if_req = 1'b0;
        wait_ready(!first_mem);
        @(posedge clk); #1;
        if_req = 1'b0; mem_r_en = 1'b0;

        // Reset during the second ACCESS cycle of a read.
        @(posedge clk); #1;
        mem_r_en = 1'b1; mem_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sram_oe) break;
        end
        check_eq("mid_rst_started", {63'd0, sram_oe}, 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_oe", {63'd0, sram_oe}, 64'd0);
        check_eq("mid_rst_mem_rdata", 64'(mem_rdata), 64'd0);
        check_eq("mid_rst_if_rdata", 64'(if_rdata), 64'd0);
        check_eq("mid_rst_sram_addr", 64'(sram_addr), 64'd0);
        mem_r_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid_rst_no_ready", {62'd0, if_ready, mem_ready}, 64'd0);
        end
        rst = 1'b1;
        exp_mem_rdata = 32'h0;
        exp_if_rdata  = 32'h0;
        prio_mem      = 1'b1;
        do_txn(1, 32'h0000_0010, 32'h0, 0);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        // WAIT_CYCLES=0 back-to-back fetches.
        @(posedge clk); #1;
        if_req0 = 1'b1; if_addr0 = 32'h0;
        for (int k = 0; k < 4; k++) begin
            gap = 0; oe_cnt = 0;
            forever begin
                @(negedge clk);
                gap++;
                if (sram_oe0) oe_cnt++;
                if (if_ready0 || gap > 20) break;
            end
            check_eq("w0_ready", {63'd0, if_ready0}, 64'd1);
            check_eq("w0_if_rdata", 64'(if_rdata0), 64'(32'hA5A5_0000 | (32'(k) * 32'd1)));
            check_eq("w0_access_cycles", 64'(oe_cnt), 64'd1);
            if (k > 0) check_eq("w0_ready_period", 64'(gap), 64'd3);
            $display("[TB] txn w0 fetch addr=0x%0h rdata=0x%08h period=%0d", 4 * k, if_rdata0, gap);
            if_addr0 = 32'(4 * (k + 1));
        end
        if_req0 = 1'b0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
